// File: rtl/count_pkg.sv
// ============================================================================
// Module      : count_pkg
// Description : Shared definitions for the 4-bit count stage and its command
//               sequencer: counting-mode encodings and FSM state encoding.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : none (package)
// ============================================================================
`default_nettype none

package count_pkg;

  typedef logic [1:0] modo_t;

  // Counting modes understood by the count stage.
  localparam modo_t PLUSONE    = 2'b00;
  localparam modo_t MINUSONE   = 2'b01;
  localparam modo_t MINUSTHREE = 2'b10;
  localparam modo_t LOAD       = 2'b11;

  // Sequencer FSM encoding.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/count_seq_if.sv
// ============================================================================
// Module      : count_seq_if
// Description : Command channel of the count sequencer (valid/ready handshake
//               carrying mode, load value and cycle count).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals     : cmd_valid  command present (master -> slave)
//               cmd_ready  slave can accept (slave -> master)
//               cmd_modo   counting mode
//               cmd_d      load value
//               cmd_len    enabled-cycle count, 0 encodes 2^LEN_W
// ============================================================================
`default_nettype none

interface count_seq_if
  import count_pkg::*;
#(
  parameter int LEN_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  modo_t            cmd_modo;
  logic [3:0]       cmd_d;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_modo,
    output cmd_d,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_modo,
    input  cmd_d,
    input  cmd_len,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/count_seq_fifo.sv
// ============================================================================
// Module      : count_seq_fifo
// Description : Synchronous FIFO for queued sequencer commands. Full/empty
//               come from read/write pointers one bit wider than the address.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk      clock, rising edge
//               reset    asynchronous active-low reset (empties the FIFO)
//               push_i   write wr_data_i (ignored when full)
//               wr_data_i
//               pop_i    advance read pointer (ignored when empty)
//               rd_data_o head entry
//               full_o / empty_o
// ============================================================================
`default_nettype none

module count_seq_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  // Same address with differing wrap bits means the writer is a lap ahead.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/count_seq.sv
// ============================================================================
// Module      : count_seq
// Description : Command sequencer feeding the 4-bit count stage. Buffers
//               {modo, D, len} commands and drives enable/modo/D so each one
//               runs for exactly len enabled edges, back-to-back, with pause.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk     clock, rising edge
//               reset   asynchronous active-low reset
//               cmd     command channel (slave side of count_seq_if)
//               pause   suspends issue; counter holds its value
//               enable  to count.enable
//               modo    to count.modo
//               D       to count.D
//               busy    a command is executing
//               done    one-cycle pulse when a command completes
// ============================================================================
`default_nettype none

module count_seq
  import count_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  wire logic   clk,
  input  wire logic   reset,
  count_seq_if.slave  cmd,
  input  wire logic   pause,
  output logic        enable,
  output modo_t       modo,
  output logic [3:0]  D,
  output logic        busy,
  output logic        done
);

  localparam int              FW       = 6 + LEN_W;
  localparam logic [LEN_W:0]  REM_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]  REM_FULL = {1'b1, {LEN_W{1'b0}}};

  logic [0:0]     state_q, state_d;
  logic [LEN_W:0] rem_q, rem_d;
  logic           enable_q, enable_d;
  modo_t          modo_q, modo_d;
  logic [3:0]     d_q, d_d;
  logic           done_q, done_d;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [FW-1:0]  w_head;
  modo_t          w_head_modo;
  logic [3:0]     w_head_d;
  logic [LEN_W-1:0] w_head_len;
  logic [LEN_W:0] w_head_rem;
  logic [LEN_W:0] w_rem_after;

  // ---------------------------------------------------------------- FIFO
  assign cmd.cmd_ready = !w_full;
  assign w_push        = cmd.cmd_valid && !w_full;

  count_seq_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (w_push),
    .wr_data_i ({cmd.cmd_modo, cmd.cmd_d, cmd.cmd_len}),
    .pop_i     (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  assign w_head_modo = w_head[FW-1 -: 2];
  assign w_head_d    = w_head[LEN_W +: 4];
  assign w_head_len  = w_head[LEN_W-1:0];
  // A zero length field stands for the full 2^LEN_W cycles.
  assign w_head_rem  = (w_head_len == '0) ? REM_FULL : {1'b0, w_head_len};

  // The edge being evaluated consumes one cycle only if enable is high now.
  assign w_rem_after = enable_q ? (rem_q - REM_ONE) : rem_q;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d  = state_q;
    rem_d    = w_rem_after;
    enable_d = enable_q;
    modo_d   = modo_q;
    d_d      = d_q;
    done_d   = 1'b0;
    w_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!w_empty) begin
          w_pop    = 1'b1;
          state_d  = RUN;
          rem_d    = w_head_rem;
          modo_d   = w_head_modo;
          d_d      = w_head_d;
          enable_d = !pause;
        end else begin
          enable_d = 1'b0;
        end
      end
      RUN: begin
        if (w_rem_after != '0) begin
          enable_d = !pause;
        end else begin
          done_d = 1'b1;
          // Chain straight into the next command so enable has no bubble.
          if (!w_empty) begin
            w_pop    = 1'b1;
            rem_d    = w_head_rem;
            modo_d   = w_head_modo;
            d_d      = w_head_d;
            enable_d = !pause;
          end else begin
            state_d  = IDLE;
            enable_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      enable_q <= 1'b0;
      modo_q   <= PLUSONE;
      d_q      <= 4'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      enable_q <= enable_d;
      modo_q   <= modo_d;
      d_q      <= d_d;
      done_q   <= done_d;
    end
  end

  assign enable = enable_q;
  assign modo   = modo_q;
  assign D      = d_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq.sv
// ============================================================================
// Module      : tb_count_seq
// Description : Directed self-checking bench for count_seq. A behavioural
//               4-bit count stage is attached to enable/modo/D so counter
//               values can be checked alongside the sequencer outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_seq;
  import count_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pause = 1'b0;
  logic       enable;
  modo_t      modo;
  logic [3:0] D;
  logic       busy;
  logic       done;

  logic [3:0] cnt;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_en = 0;
  int         n_done = 0;

  count_seq_if #(.LEN_W(4)) u_if ();

  count_seq #(
    .DEPTH (4),
    .LEN_W (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (u_if),
    .pause  (pause),
    .enable (enable),
    .modo   (modo),
    .D      (D),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Attached count stage.
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 4'h0;
    else if (enable) begin
      case (modo)
        PLUSONE:    cnt <= cnt + 4'd1;
        MINUSONE:   cnt <= cnt - 4'd1;
        MINUSTHREE: cnt <= cnt - 4'd3;
        default:    cnt <= D;
      endcase
    end
  end

  // Enabled cycles and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (enable) n_en <= n_en + 1;
      if (done)   n_done <= n_done + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns one step after the accepting edge.
  task automatic push(input modo_t m, input logic [3:0] d, input logic [3:0] l);
    int w;
    w = 0;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_modo  = m;
    u_if.cmd_d     = d;
    u_if.cmd_len   = l;
    while (!u_if.cmd_ready && w < 50) begin
      tick();
      w++;
    end
    chk("push_wait", 32'(w < 50), 32'd1);
    tick();
    u_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, k, wraps;
    logic [3:0] prev;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_modo  = PLUSONE;
    u_if.cmd_d     = 4'h0;
    u_if.cmd_len   = 4'h0;

    // ---------------- reset state
    tick(); tick(); tick();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_modo",   32'(modo),   32'd0);
    chk("rst_D",      32'(D),      32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_ready",  32'(u_if.cmd_ready), 32'd1);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("idle_busy",  32'(busy),   32'd0);
    chk("idle_en",    32'(enable), 32'd0);

    // ---------------- single commands: LOAD A len1, PLUSONE len3
    e0 = n_en; d0 = n_done;
    push(LOAD, 4'hA, 4'd1);
    push(PLUSONE, 4'h0, 4'd3);
    chk("t1_en",   32'(enable), 32'd1);
    chk("t1_modo", 32'(modo),   32'(LOAD));
    chk("t1_D",    32'(D),      32'hA);
    chk("t1_busy", 32'(busy),   32'd1);
    tick();
    chk("t1_cntA",  32'(cnt),   32'hA);
    chk("t1_done1", 32'(done),  32'd1);
    chk("t1_modo2", 32'(modo),  32'(PLUSONE));
    chk("t1_en2",   32'(enable),32'd1);
    tick();
    chk("t1_cntB",  32'(cnt),   32'hB);
    chk("t1_nodone",32'(done),  32'd0);
    tick();
    chk("t1_cntC",  32'(cnt),   32'hC);
    tick();
    chk("t1_cntD",  32'(cnt),   32'hD);
    chk("t1_done2", 32'(done),  32'd1);
    chk("t1_en_off",32'(enable),32'd0);
    chk("t1_idle",  32'(busy),  32'd0);
    tick();
    chk("t1_done_clr", 32'(done), 32'd0);
    chk("t1_modo_hold",32'(modo), 32'(PLUSONE));
    chk("t1_en_cnt",   32'(n_en - e0),   32'd4);
    chk("t1_done_cnt", 32'(n_done - d0), 32'd2);

    // ---------------- len 0 -> 16 cycles of MINUSONE from D
    e0 = n_en; d0 = n_done;
    push(MINUSONE, 4'h0, 4'd0);
    prev = cnt; wraps = 0; k = 0;
    while (!done && k < 40) begin
      tick();
      if (prev == 4'h0 && cnt == 4'hF) wraps++;
      prev = cnt;
      k++;
    end
    chk("t2_bound",  32'(k < 40), 32'd1);
    chk("t2_en_cnt", 32'(n_en - e0), 32'd16);
    chk("t2_cnt",    32'(cnt), 32'hD);
    chk("t2_wraps",  32'(wraps), 32'd1);
    tick();
    chk("t2_done_cnt", 32'(n_done - d0), 32'd1);

    // ---------------- pause for 2 cycles inside MINUSTHREE len4
    e0 = n_en;
    push(MINUSTHREE, 4'h0, 4'd4);
    tick();
    chk("t3_en_on", 32'(enable), 32'd1);
    tick();
    chk("t3_cnt1", 32'(cnt), 32'hA);
    pause = 1'b1;
    tick();
    chk("t3_gap1_en",  32'(enable), 32'd0);
    chk("t3_gap1_cnt", 32'(cnt),    32'h7);
    chk("t3_gap1_modo",32'(modo),   32'(MINUSTHREE));
    tick();
    chk("t3_gap2_en",  32'(enable), 32'd0);
    chk("t3_gap2_cnt", 32'(cnt),    32'h7);
    chk("t3_gap2_busy",32'(busy),   32'd1);
    pause = 1'b0;
    tick();
    chk("t3_resume",   32'(enable), 32'd1);
    chk("t3_hold_cnt", 32'(cnt),    32'h7);
    tick();
    chk("t3_cnt3",     32'(cnt),    32'h4);
    tick();
    chk("t3_done",     32'(done),   32'd1);
    chk("t3_cnt4",     32'(cnt),    32'h1);
    chk("t3_en_cnt",   32'(n_en - e0), 32'd4);

    // ---------------- fill FIFO while paused, then run 5 back-to-back
    tick();
    e0 = n_en; d0 = n_done;
    pause = 1'b1;
    push(LOAD, 4'h3, 4'd2);
    push(PLUSONE, 4'h0, 4'd2);
    push(PLUSONE, 4'h0, 4'd2);
    push(PLUSONE, 4'h0, 4'd2);
    push(PLUSONE, 4'h0, 4'd2);
    chk("t4_full",  32'(u_if.cmd_ready), 32'd0);
    chk("t4_busy",  32'(busy),   32'd1);
    chk("t4_stall", 32'(enable), 32'd0);
    pause = 1'b0;
    tick();
    chk("t4_en0",       32'(enable), 32'd1);
    chk("t4_still_full",32'(u_if.cmd_ready), 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t4_no_gap", 32'(enable), 32'd1);
    end
    tick();
    chk("t4_last_done", 32'(done),   32'd1);
    chk("t4_en_off",    32'(enable), 32'd0);
    chk("t4_cnt",       32'(cnt),    32'hB);
    chk("t4_ready",     32'(u_if.cmd_ready), 32'd1);
    chk("t4_en_cnt",    32'(n_en - e0), 32'd10);
    tick();
    chk("t4_done_cnt",  32'(n_done - d0), 32'd5);

    // ---------------- asynchronous reset mid-command
    push(LOAD, 4'h5, 4'd8);
    push(MINUSONE, 4'h9, 4'd3);
    tick();
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_modo", 32'(modo), 32'(LOAD));
    chk("t5_D",    32'(D),    32'h5);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_en",    32'(enable), 32'd0);
    chk("t5_rst_modo",  32'(modo),   32'd0);
    chk("t5_rst_D",     32'(D),      32'd0);
    chk("t5_rst_busy",  32'(busy),   32'd0);
    chk("t5_rst_done",  32'(done),   32'd0);
    chk("t5_rst_ready", 32'(u_if.cmd_ready), 32'd1);
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("t5_post_busy", 32'(busy),   32'd0);
    chk("t5_post_en",   32'(enable), 32'd0);
    chk("t5_post_cnt",  32'(cnt),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/count_seq.md
# count_seq

Command sequencer sitting directly upstream of the 4-bit `count` stage. It accepts counting commands (mode, load value, cycle count) over a valid/ready handshake, buffers them in a small FIFO, and drives the counter's `enable`, `modo` and `D` inputs so each command runs for exactly its requested number of enabled clock edges. Commands run back-to-back without gaps, and a `pause` input lets the counter's hold behaviour be exercised.

## Interface
- `DEPTH`, 4: command FIFO entries; must be a power of 2, at least 2.
- `LEN_W`, 4: width of the cycle-count field. A value of 0 encodes 2^LEN_W cycles.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_modo`  in  2  counting mode for the command.
- `cmd_d`  in  4  load value for the command.
- `cmd_len`  in  LEN_W  number of enabled cycles for the command.
- `pause`  in  1  suspends issue; the counter holds its value.
- `enable`  out  1  to `count.enable`.
- `modo`  out  2  to `count.modo`.
- `D`  out  4  to `count.D`.
- `busy`  out  1  a command is executing.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- **Push:** a command is written into the FIFO on any edge where `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`.
  - There is no bypass: a push into an empty FIFO is visible to the FSM one cycle later.
  - When full, `cmd_ready` is 0 even if a pop occurs on the same edge.
- **Registers:** `state` (IDLE/RUN) and `rem`, which is LEN_W+1 bits.
- **Pop:** the head is popped whenever a new command starts.
  - On pop: `modo` and `D` load from the head entry.
  - `rem` loads `len`, or 2^LEN_W when `len` is 0.
- **Issued cycle:** every edge where `enable == 1` counts as one issued cycle. On that edge, `rem_after = rem - 1`; otherwise `rem_after = rem`.
- **IDLE:**
  - FIFO non-empty: pop, then `state <= RUN`, `enable <= !pause`.
  - FIFO empty: stay in IDLE with `enable <= 0`.
- **RUN, `rem_after > 0`:** `enable <= !pause`.
- **RUN, `rem_after == 0`:** the command is complete.
  - `done <= 1`.
  - If the FIFO is non-empty: pop the next command, stay in RUN, `enable <= !pause`. There is no bubble.
  - Otherwise: `state <= IDLE`, `enable <= 0`.
- **Pause:**
  - `pause` deasserts `enable` on the following cycle.
  - `rem` is frozen while `enable == 0`.
  - `modo` and `D` are held.
- **Outputs:**
  - `modo` and `D` hold their last values while idle.
  - `busy = (state == RUN)`.
  - `done` is 0 on every edge not marked above.
- **Reset** (asserted asynchronously at any time, including mid-command):
  - `state` = IDLE, FIFO emptied, `rem` = 0.
  - `enable` = 0, `modo` = 2'b00, `D` = 4'b0000.
  - `busy` = 0, `done` = 0, `cmd_ready` = 1.
  - All queued commands are discarded.

## Timing
- All outputs are registered, except `cmd_ready`, which is decoded from the registered FIFO count.
- **Latency:** a command accepted at edge E0 into an empty idle block gives the following, with `pause = 0`:
  - Pop at E1.
  - `enable` high during the cycles after E1 through E(N).
  - The counter steps at edges E2 through E(N+1).
  - `done` is high during the cycle after E(N+1).
- **Back-to-back commands:**
  - `enable` stays continuously high.
  - `modo` and `D` change on the completing edge.
  - `done` pulses once per command.
- **FIFO:** full/empty are derived from read/write pointers that are one bit wider than the address. Pointers wrap modulo 2*DEPTH.

## Structure
- **Shared package `count_pkg`:**
  - Mode constants: PLUSONE = 2'b00, MINUSONE = 2'b01, MINUSTHREE = 2'b10, LOAD = 2'b11.
  - FSM state encoding: IDLE = 1'b0, RUN = 1'b1.
  - The counter and the sequencer both use this package.
- **Sub-module `count_seq_fifo`:** synchronous FIFO, width 6+LEN_W, depth DEPTH, with `push`/`pop`/`full`/`empty` and the same asynchronous active-low reset.

## Test plan
- **Reset:** assert `reset` = 0 mid-RUN → outputs go to 0 immediately (`enable` 0, `modo` 00, `D` 0, `busy` 0, `done` 0) and `cmd_ready` goes to 1; release with no push → block stays IDLE.
- **Single command:** push {LOAD, D = 4'hA, len = 1}, then {PLUSONE, len = 3} → `enable` high for 4 consecutive cycles; the attached counter reads A, B, C, D; `done` pulses twice, one cycle after each final enabled edge.
- **Zero-length encoding:** push {MINUSONE, len = 0} with LEN_W = 4 → exactly 16 enabled cycles; the counter wraps 0→F once; one `done` pulse.
- **Pause:** pause 2 cycles midway through {MINUSTHREE, len = 4} → `enable` shows a 2-cycle gap, 4 enabled cycles total, and the counter value is unchanged during the gap.
- **Full FIFO:** push 5 commands of len = 2 with DEPTH = 4 while RUN is stalled by `pause` → `cmd_ready` = 0 after the FIFO holds 4; release `pause` → all 5 run back-to-back with no `enable` gap and 5 `done` pulses.
